dot_prod_bias_sat: RTL and testbench

Parametrised successor to the current matrix-vector dot-product engine. It computes NROW parallel dot products of a weight column stream against an input vector of runtime-selectable length, and adds a per-row bias. Rounding and saturation back to the Q(QN.QM) format are mode-selectable. It sits between weightRAM and the activation stage of the RNN layer, and keeps the column-address / dataReady interface the layer already uses, plus a start/busy handshake.

---
 rtl/dot_prod_bias_sat_pkg.sv | 35 +++
 rtl/dot_prod_bias_sat_row_mac.sv | 101 ++++++++++
 rtl/dot_prod_bias_sat.sv | 168 ++++++++++++++++
 tb/tb_dot_prod_bias_sat.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_prod_bias_sat_pkg.sv
// Shared definitions for the dot_prod_bias_sat engine.
//   - width helpers for the data word, column address and accumulator
//   - FSM state encoding
//   - saturation bounds derived from the Q(QN.QM) format
package dot_prod_bias_sat_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FINAL = 2'd3
  } state_e;

  function automatic int unsigned data_bw(input int unsigned qn, input int unsigned qm);
    return qn + qm + 1;
  endfunction

  function automatic int unsigned addr_bw(input int unsigned ncol);
    return (ncol > 1) ? $clog2(ncol) : 1;
  endfunction

  function automatic int unsigned acc_bw(input int unsigned bw, input int unsigned ncol);
    return 2 * bw + addr_bw(ncol);
  endfunction

  // Largest / smallest representable Q(QN.QM) value, in LSBs.
  function automatic longint sat_max(input int unsigned qn, input int unsigned qm);
    return (longint'(1) << (qn + qm)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned qn, input int unsigned qm);
    return -(longint'(1) << (qn + qm));
  endfunction

endpackage

// File: rtl/dot_prod_bias_sat_row_mac.sv
// Single-row multiply-accumulate with bias / rounding / saturation finalise.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clr_i           clear accumulator and latch bias_i (run start)
//   bias_i          row bias, Q(QN.QM)
//   acc_en_i        accumulate w_i*x_i this cycle
//   w_i, x_i        signed weight / input element
//   round_i         1 = round-half-up, 0 = truncate (latched by the top)
//   fin_i           register finalised result and saturation flag
//   out_o, sat_o    registered result and saturation flag
module dot_prod_row_mac
  import dot_prod_bias_sat_pkg::*;
#(
  parameter int unsigned QN           = 6,
  parameter int unsigned QM           = 11,
  parameter int unsigned BITWIDTH     = data_bw(QN, QM),
  parameter int unsigned ACC_BITWIDTH = acc_bw(BITWIDTH, 8)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic [BITWIDTH-1:0]        bias_i,
  input  logic                       acc_en_i,
  input  logic signed [BITWIDTH-1:0] w_i,
  input  logic signed [BITWIDTH-1:0] x_i,
  input  logic                       round_i,
  input  logic                       fin_i,
  output logic [BITWIDTH-1:0]        out_o,
  output logic                       sat_o
);

  // One guard bit above the accumulator so the bias/round add cannot wrap.
  localparam int unsigned SUM_W = ACC_BITWIDTH + 1;
  localparam logic signed [SUM_W-1:0] SMAX = SUM_W'(sat_max(QN, QM));
  localparam logic signed [SUM_W-1:0] SMIN = SUM_W'(sat_min(QN, QM));
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(longint'(1) << (QM - 1));

  logic signed [ACC_BITWIDTH-1:0] acc_q, acc_d;
  logic signed [BITWIDTH-1:0]     bias_q, bias_d;
  logic [BITWIDTH-1:0]            out_q, out_d;
  logic                           sat_q, sat_d;

  logic signed [2*BITWIDTH-1:0]   prod;
  logic signed [SUM_W-1:0]        sum;
  logic signed [SUM_W-1:0]        shifted;
  logic [BITWIDTH-1:0]            res;
  logic                           res_sat;

  always_comb begin
    prod   = w_i * x_i;
    acc_d  = acc_q;
    bias_d = bias_q;
    if (clr_i) begin
      acc_d  = '0;
      bias_d = bias_i;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_BITWIDTH'(prod);
    end
  end

  always_comb begin
    sum = SUM_W'(acc_q) + (SUM_W'(bias_q) <<< QM);
    if (round_i) begin
      sum = sum + HALF;
    end
    shifted = sum >>> QM;
    res     = shifted[BITWIDTH-1:0];
    res_sat = 1'b0;
    if (shifted > SMAX) begin
      res     = SMAX[BITWIDTH-1:0];
      res_sat = 1'b1;
    end else if (shifted < SMIN) begin
      res     = SMIN[BITWIDTH-1:0];
      res_sat = 1'b1;
    end
    out_d = out_q;
    sat_d = sat_q;
    if (fin_i) begin
      out_d = res;
      sat_d = res_sat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      bias_q <= '0;
      out_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      bias_q <= bias_d;
      out_q  <= out_d;
      sat_q  <= sat_d;
    end
  end

  assign out_o = out_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/dot_prod_bias_sat.sv
// NROW-row dot-product engine with per-row bias, optional rounding and
// saturation to Q(QN.QM). Streams weight columns by colAddress.
// Ports:
//   clock, reset      clock, synchronous active-low reset
//   start             run request, honoured only when idle and not busy
//   ncol_cfg          active column count (0 or >NCOL means NCOL)
//   round_mode        1 = round-half-up, 0 = truncate
//   biasVec           per-row bias, row j at [j*BITWIDTH +: BITWIDTH]
//   weightMemOutput   weight column, row j at [j*BITWIDTH +: BITWIDTH]
//   inputVec          input element for the addressed column
//   colAddress        column read address
//   busy              accepted start through dataReady cycle inclusive
//   dataReady         one-cycle pulse, outputVec valid
//   outputVec         results, row j at [j*BITWIDTH +: BITWIDTH]
//   satFlags          per-row saturation flag of the last run
module dot_prod_bias_sat
  import dot_prod_bias_sat_pkg::*;
#(
  parameter int unsigned NROW          = 16,
  parameter int unsigned NCOL          = 8,
  parameter int unsigned QN            = 6,
  parameter int unsigned QM            = 11,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned BITWIDTH      = data_bw(QN, QM),
  parameter int unsigned ADDR_BITWIDTH = addr_bw(NCOL),
  parameter int unsigned ACC_BITWIDTH  = acc_bw(BITWIDTH, NCOL)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_BITWIDTH:0]       ncol_cfg,
  input  logic                         round_mode,
  input  logic [BITWIDTH*NROW-1:0]     biasVec,
  input  logic [BITWIDTH*NROW-1:0]     weightMemOutput,
  input  logic [BITWIDTH-1:0]          inputVec,
  output logic [ADDR_BITWIDTH-1:0]     colAddress,
  output logic                         busy,
  output logic                         dataReady,
  output logic [BITWIDTH*NROW-1:0]     outputVec,
  output logic [NROW-1:0]              satFlags
);

  localparam logic [ADDR_BITWIDTH:0] NCOL_W     = (ADDR_BITWIDTH + 1)'(NCOL);
  localparam logic [2:0]             DRAIN_LAST = 3'(MEM_LATENCY - 1);

  state_e                   state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] col_q, col_d;
  logic [ADDR_BITWIDTH-1:0] last_q, last_d;
  logic [2:0]               drain_q, drain_d;
  logic                     busy_q, busy_d;
  logic                     rdy_q, rdy_d;
  logic                     round_q, round_d;
  logic [MEM_LATENCY-1:0]   vld_q;

  logic [ADDR_BITWIDTH:0]   ncol_eff;
  logic                     clr;
  logic                     fin;
  logic                     acc_en;

  always_comb begin
    ncol_eff = ncol_cfg;
    if (ncol_cfg == '0 || ncol_cfg > NCOL_W) begin
      ncol_eff = NCOL_W;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    last_d  = last_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    round_d = round_q;
    clr     = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // busy_q is still high during the dataReady cycle, which blocks
        // a start arriving together with dataReady.
        if (start && !busy_q) begin
          state_d = S_ISSUE;
          col_d   = '0;
          last_d  = ADDR_BITWIDTH'(ncol_eff - 1'b1);
          busy_d  = 1'b1;
          round_d = round_mode;
          clr     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (col_q == last_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_FINAL;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_FINAL: begin
        fin     = 1'b1;
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      last_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      round_q <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      last_q   <= last_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      round_q  <= round_d;
      // Tracks which cycles carry returning memory data.
      vld_q[0] <= (state_q == S_ISSUE);
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign acc_en = vld_q[MEM_LATENCY-1];

  for (genvar j = 0; j < NROW; j++) begin : g_row
    dot_prod_row_mac #(
      .QN          (QN),
      .QM          (QM),
      .BITWIDTH    (BITWIDTH),
      .ACC_BITWIDTH(ACC_BITWIDTH)
    ) u_mac (
      .clk_i   (clock),
      .rst_ni  (reset),
      .clr_i   (clr),
      .bias_i  (biasVec[j*BITWIDTH +: BITWIDTH]),
      .acc_en_i(acc_en),
      .w_i     (weightMemOutput[j*BITWIDTH +: BITWIDTH]),
      .x_i     (inputVec),
      .round_i (round_q),
      .fin_i   (fin),
      .out_o   (outputVec[j*BITWIDTH +: BITWIDTH]),
      .sat_o   (satFlags[j])
    );
  end

  assign colAddress = col_q;
  assign busy       = busy_q;
  assign dataReady  = rdy_q;

endmodule

// File: tb/tb_dot_prod_bias_sat.sv
// Bench for dot_prod_bias_sat: two instances (memory latency 1 and 3) share
// configuration and memory contents; each has its own latency-matched
// memory model. Results are checked against an arithmetic reference model.
module tb_dot_prod_bias_sat;

  localparam int NROW = 16;
  localparam int NCOL = 8;
  localparam int QM   = 11;
  localparam int BW   = 18;
  localparam int AW   = 3;
  localparam int VW   = BW * NROW;
  localparam longint SMAX = 131071;
  localparam longint SMIN = -131072;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   ncol_cfg = '0;
  logic          round_mode = 1'b0;
  logic [VW-1:0] biasVec = '0;

  logic [VW-1:0]   wout1, wout3, ov1, ov3;
  logic [BW-1:0]   x1, x3;
  logic [AW-1:0]   ca1, ca3;
  logic            busy1, busy3, rdy1, rdy3;
  logic [NROW-1:0] sf1, sf3;

  logic signed [BW-1:0] W [NCOL][NROW];
  logic signed [BW-1:0] X [NCOL];
  logic [AW-1:0] p1 = '0;
  logic [AW-1:0] p3 [3] = '{default: '0};

  int errors = 0;
  int checks = 0;

  // Recorded per-cycle observations of the last run (cycle 1 = first after accept).
  int rdy1_n, rdy3_n, rdy1_at, rdy3_at;
  logic [AW-1:0]   a1 [40];
  logic [AW-1:0]   a3 [40];
  logic            b1 [40];
  logic            b3 [40];
  logic [VW-1:0]   o1 [40];
  logic [VW-1:0]   o3 [40];
  logic [NROW-1:0] s1 [40];
  logic [NROW-1:0] s3 [40];

  dot_prod_bias_sat #(.MEM_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .start(start), .ncol_cfg(ncol_cfg),
    .round_mode(round_mode), .biasVec(biasVec), .weightMemOutput(wout1),
    .inputVec(x1), .colAddress(ca1), .busy(busy1), .dataReady(rdy1),
    .outputVec(ov1), .satFlags(sf1)
  );

  dot_prod_bias_sat #(.MEM_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .start(start), .ncol_cfg(ncol_cfg),
    .round_mode(round_mode), .biasVec(biasVec), .weightMemOutput(wout3),
    .inputVec(x3), .colAddress(ca3), .busy(busy3), .dataReady(rdy3),
    .outputVec(ov3), .satFlags(sf3)
  );

  // Memory models: registered address pipeline, data read combinationally.
  always @(posedge clock) begin
    p1    <= ca1;
    p3[0] <= ca3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  always_comb begin
    wout1 = '0;
    wout3 = '0;
    for (int j = 0; j < NROW; j++) begin
      wout1[j*BW +: BW] = W[p1][j];
      wout3[j*BW +: BW] = W[p3[2]][j];
    end
    x1 = X[p1];
    x3 = X[p3[2]];
  end

  function automatic int neff(input int n);
    return (n == 0 || n > NCOL) ? NCOL : n;
  endfunction

  function automatic logic [VW-1:0] rnd_vec(input int mag);
    logic [VW-1:0] v;
    int t;
    v = '0;
    for (int j = 0; j < NROW; j++) begin
      t = int'($urandom_range(0, 2 * mag)) - mag;
      v[j*BW +: BW] = BW'(t);
    end
    return v;
  endfunction

  task automatic fill_const(input int w, input int x);
    for (int k = 0; k < NCOL; k++) begin
      X[k] = BW'(x);
      for (int j = 0; j < NROW; j++) W[k][j] = BW'(w);
    end
  endtask

  task automatic fill_rand(input int wmag, input int xmag);
    for (int k = 0; k < NCOL; k++) begin
      X[k] = BW'(int'($urandom_range(0, 2 * xmag)) - xmag);
      for (int j = 0; j < NROW; j++) W[k][j] = BW'(int'($urandom_range(0, 2 * wmag)) - wmag);
    end
  endtask

  // Reference: exact dot product, bias scaled to product format, optional
  // half-LSB add, floor division by 2^QM, clamp to the 18-bit signed range.
  task automatic model(input int n, input bit r, input logic [VW-1:0] b,
                       output logic [VW-1:0] ev, output logic [NROW-1:0] es);
    longint acc, bj, v, q;
    ev = '0;
    es = '0;
    for (int j = 0; j < NROW; j++) begin
      acc = 0;
      for (int k = 0; k < n; k++) acc += longint'(W[k][j]) * longint'(X[k]);
      bj = longint'($signed(b[j*BW +: BW]));
      v  = acc + bj * 2048 + (r ? 1024 : 0);
      q  = v >>> QM;
      if (q > SMAX) begin q = SMAX; es[j] = 1'b1; end
      else if (q < SMIN) begin q = SMIN; es[j] = 1'b1; end
      ev[j*BW +: BW] = q[BW-1:0];
    end
  endtask

  task automatic launch(input int n, input bit r, input logic [VW-1:0] b);
    @(negedge clock);
    start      = 1'b1;
    ncol_cfg   = (AW + 1)'(n);
    round_mode = r;
    biasVec    = b;
  endtask

  // Observes 32 cycles after the accepting edge. Configuration inputs are
  // scrambled after acceptance; optional extra starts and a reset pulse.
  task automatic run_collect(input int rst_at, input bit extra);
    rdy1_n = 0; rdy3_n = 0; rdy1_at = 0; rdy3_at = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      start = 1'b0;
      reset = 1'b1;
      a1[i] = ca1; a3[i] = ca3; b1[i] = busy1; b3[i] = busy3;
      o1[i] = ov1; o3[i] = ov3; s1[i] = sf1; s3[i] = sf3;
      if (rdy1) begin rdy1_n++; if (rdy1_at == 0) rdy1_at = i; end
      if (rdy3) begin rdy3_n++; if (rdy3_at == 0) rdy3_at = i; end
      if (i == 1) begin
        ncol_cfg = (AW + 1)'($urandom); round_mode = 1'($urandom); biasVec = rnd_vec(100000);
      end
      if (i == rst_at) reset = 1'b0;
      if (extra && (i == 2 || i == 5 || rdy1)) begin
        start = 1'b1;
        ncol_cfg = (AW + 1)'($urandom); round_mode = 1'($urandom); biasVec = rnd_vec(100000);
      end
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (ov1 !== '0)   begin errors++; $display("FAIL reset_ov1 got=%h exp=0", ov1); end
    checks++; if (sf1 !== '0)   begin errors++; $display("FAIL reset_sf1 got=%h exp=0", sf1); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_rdy1 got=%b exp=0", rdy1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    checks++; if (ca1 !== '0)   begin errors++; $display("FAIL reset_ca1 got=%0d exp=0", ca1); end
    checks++; if (ov3 !== '0)   begin errors++; $display("FAIL reset_ov3 got=%h exp=0", ov3); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3 got=%b exp=0", busy3); end
    checks++; if (ca3 !== '0)   begin errors++; $display("FAIL reset_ca3 got=%0d exp=0", ca3); end
    reset = 1'b1;
  endtask

  task automatic test_unity();
    logic [VW-1:0] ev; logic [NROW-1:0] es;
    fill_const(2048, 2048);
    launch(0, 1'b0, '0);
    run_collect(0, 1'b0);
    model(NCOL, 1'b0, '0, ev, es);
    checks++; if (rdy1_at !== 11) begin errors++; $display("FAIL unity_rdy_cycle got=%0d exp=11", rdy1_at); end
    checks++; if (rdy1_n !== 1) begin errors++; $display("FAIL unity_rdy_count got=%0d exp=1", rdy1_n); end
    checks++; if (o1[11] !== {NROW{18'h04000}}) begin errors++; $display("FAIL unity_out got=%h exp=%h", o1[11], {NROW{18'h04000}}); end
    checks++; if (s1[11] !== '0) begin errors++; $display("FAIL unity_sat got=%h exp=0", s1[11]); end
    checks++; if (b1[1] !== 1'b1 || b1[11] !== 1'b1 || b1[12] !== 1'b0) begin errors++; $display("FAIL unity_busy got=%b%b%b exp=110", b1[1], b1[11], b1[12]); end
    for (int k = 0; k < NCOL; k++) begin
      checks++; if (a1[k+1] !== AW'(k)) begin errors++; $display("FAIL unity_addr got=%0d exp=%0d", a1[k+1], k); end
    end
    checks++; if (rdy3_at !== 13) begin errors++; $display("FAIL unity_rdy3_cycle got=%0d exp=13", rdy3_at); end
    checks++; if (o3[13] !== ev) begin errors++; $display("FAIL unity_out3 got=%h exp=%h", o3[13], ev); end
  endtask

  task automatic test_saturate();
    fill_const(32'h10000, 4096);
    launch(8, 1'b0, '0);
    run_collect(0, 1'b0);
    checks++; if (o1[11] !== {NROW{18'h1FFFF}}) begin errors++; $display("FAIL satpos_out got=%h", o1[11]); end
    checks++; if (s1[11] !== '1) begin errors++; $display("FAIL satpos_flags got=%h exp=ffff", s1[11]); end
    checks++; if (o3[13] !== {NROW{18'h1FFFF}}) begin errors++; $display("FAIL satpos_out3 got=%h", o3[13]); end
    fill_const(32'h10000, -4096);
    launch(8, 1'b1, '0);
    run_collect(0, 1'b0);
    checks++; if (o1[11] !== {NROW{18'h20000}}) begin errors++; $display("FAIL satneg_out got=%h", o1[11]); end
    checks++; if (s1[11] !== '1) begin errors++; $display("FAIL satneg_flags got=%h exp=ffff", s1[11]); end
    checks++; if (s3[13] !== '1) begin errors++; $display("FAIL satneg_flags3 got=%h exp=ffff", s3[13]); end
  endtask

  task automatic test_rounding();
    fill_rand(60000, 60000);
    X[0] = 18'sd1024;
    for (int j = 0; j < NROW; j++) W[0][j] = 18'sd1;
    launch(1, 1'b1, '0);
    run_collect(0, 1'b0);
    checks++; if (rdy1_at !== 4) begin errors++; $display("FAIL round_rdy_cycle got=%0d exp=4", rdy1_at); end
    checks++; if (o1[4] !== {NROW{18'h00001}}) begin errors++; $display("FAIL round_up_out got=%h", o1[4]); end
    checks++; if (o3[6] !== {NROW{18'h00001}}) begin errors++; $display("FAIL round_up_out3 got=%h", o3[6]); end
    launch(1, 1'b0, '0);
    run_collect(0, 1'b0);
    checks++; if (o1[4] !== '0) begin errors++; $display("FAIL round_trunc_out got=%h exp=0", o1[4]); end
    checks++; if (s1[4] !== '0) begin errors++; $display("FAIL round_trunc_sat got=%h exp=0", s1[4]); end
  endtask

  task automatic test_bias_short();
    logic [VW-1:0] b, ev;
    b = '0; ev = '0;
    for (int j = 0; j < NROW; j++) begin
      b[j*BW +: BW]  = BW'(j * 2048);
      ev[j*BW +: BW] = BW'((3 + j) * 2048);
    end
    fill_const(2048, 2048);
    launch(3, 1'b0, b);
    run_collect(0, 1'b0);
    checks++; if (rdy1_at !== 6) begin errors++; $display("FAIL bias_rdy_cycle got=%0d exp=6", rdy1_at); end
    checks++; if (rdy3_at !== 8) begin errors++; $display("FAIL bias_rdy3_cycle got=%0d exp=8", rdy3_at); end
    checks++; if (o1[6] !== ev) begin errors++; $display("FAIL bias_out got=%h exp=%h", o1[6], ev); end
    checks++; if (o3[8] !== ev) begin errors++; $display("FAIL bias_out3 got=%h exp=%h", o3[8], ev); end
    checks++; if (a1[1] !== 3'd0 || a1[2] !== 3'd1 || a1[3] !== 3'd2) begin errors++; $display("FAIL bias_addr_seq got=%0d,%0d,%0d exp=0,1,2", a1[1], a1[2], a1[3]); end
    checks++; if (a1[4] !== 3'd2 || a1[10] !== 3'd2) begin errors++; $display("FAIL bias_addr_hold got=%0d,%0d exp=2,2", a1[4], a1[10]); end
    checks++; if (a3[3] !== 3'd2 || a3[7] !== 3'd2) begin errors++; $display("FAIL bias_addr3 got=%0d,%0d exp=2,2", a3[3], a3[7]); end
  endtask

  task automatic test_reset_mid();
    fill_const(2048, 2048);
    launch(0, 1'b0, '0);
    run_collect(5, 1'b0);
    checks++; if (a1[5] !== 3'd4) begin errors++; $display("FAIL rstmid_addr got=%0d exp=4", a1[5]); end
    checks++; if (rdy1_n !== 0 || rdy3_n !== 0) begin errors++; $display("FAIL rstmid_no_rdy got=%0d,%0d exp=0,0", rdy1_n, rdy3_n); end
    checks++; if (o1[6] !== '0 || o3[6] !== '0) begin errors++; $display("FAIL rstmid_out got=%h exp=0", o1[6]); end
    checks++; if (b1[6] !== 1'b0 || b3[6] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b%b exp=00", b1[6], b3[6]); end
    launch(0, 1'b0, '0);
    run_collect(0, 1'b0);
    checks++; if (rdy1_at !== 11) begin errors++; $display("FAIL rstmid_rerun_cycle got=%0d exp=11", rdy1_at); end
    checks++; if (o1[11] !== {NROW{18'h04000}}) begin errors++; $display("FAIL rstmid_rerun_out got=%h", o1[11]); end
  endtask

  task automatic test_ignored_starts();
    logic [VW-1:0] bA, bB, evA, evB; logic [NROW-1:0] esA, esB;
    fill_rand(4096, 4096);
    bA = rnd_vec(8192);
    launch(5, 1'b1, bA);
    run_collect(0, 1'b0);
    model(5, 1'b1, bA, evA, esA);
    checks++; if (o1[rdy1_at] !== evA) begin errors++; $display("FAIL ign_first_out got=%h exp=%h", o1[rdy1_at], evA); end
    fill_rand(4096, 4096);
    bB = rnd_vec(8192);
    launch(0, 1'b0, bB);
    run_collect(0, 1'b1);
    model(NCOL, 1'b0, bB, evB, esB);
    checks++; if (rdy1_n !== 1 || rdy3_n !== 1) begin errors++; $display("FAIL ign_rdy_count got=%0d,%0d exp=1,1", rdy1_n, rdy3_n); end
    checks++; if (o1[5] !== evA) begin errors++; $display("FAIL ign_held_out got=%h exp=%h", o1[5], evA); end
    checks++; if (rdy1_at !== 11) begin errors++; $display("FAIL ign_rdy_cycle got=%0d exp=11", rdy1_at); end
    checks++; if (o1[11] !== evB || s1[11] !== esB) begin errors++; $display("FAIL ign_out got=%h exp=%h", o1[11], evB); end
    checks++; if (b1[12] !== 1'b0 || o1[30] !== evB) begin errors++; $display("FAIL ign_after got=%b exp=0", b1[12]); end
    checks++; if (o3[13] !== evB) begin errors++; $display("FAIL ign_out3 got=%h exp=%h", o3[13], evB); end
  endtask

  task automatic test_random();
    logic [VW-1:0] b, ev; logic [NROW-1:0] es;
    int n, ne, mag;
    bit r;
    for (int t = 0; t < 10; t++) begin
      mag = (t % 2 == 0) ? 4096 : 131071;
      fill_rand(mag, mag);
      b  = rnd_vec(mag);
      n  = int'($urandom_range(0, 15));
      r  = 1'($urandom);
      ne = neff(n);
      launch(n, r, b);
      run_collect(0, 1'b0);
      model(ne, r, b, ev, es);
      checks++; if (rdy1_at !== ne + 3) begin errors++; $display("FAIL rand_rdy_cycle n=%0d got=%0d exp=%0d", n, rdy1_at, ne + 3); end
      checks++; if (rdy3_at !== ne + 5) begin errors++; $display("FAIL rand_rdy3_cycle n=%0d got=%0d exp=%0d", n, rdy3_at, ne + 5); end
      checks++; if (o1[rdy1_at] !== ev) begin errors++; $display("FAIL rand_out n=%0d got=%h exp=%h", n, o1[rdy1_at], ev); end
      checks++; if (s1[rdy1_at] !== es) begin errors++; $display("FAIL rand_sat n=%0d got=%h exp=%h", n, s1[rdy1_at], es); end
      checks++; if (o3[rdy3_at] !== ev || s3[rdy3_at] !== es) begin errors++; $display("FAIL rand_out3 n=%0d got=%h exp=%h", n, o3[rdy3_at], ev); end
      checks++; if (a1[ne] !== AW'(ne - 1) || a1[ne + 1] !== AW'(ne - 1)) begin errors++; $display("FAIL rand_last_addr got=%0d exp=%0d", a1[ne], ne - 1); end
    end
  endtask

  initial begin
    fill_const(0, 0);
    test_reset();
    test_unity();
    test_saturate();
    test_rounding();
    test_bias_short();
    test_reset_mid();
    test_ignored_starts();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
